// File: rtl/fp_addsub_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_norm_pipe
// Description : Three-stage FP adder back end: signed add of aligned
//               magnitudes, normalise, round-to-nearest-even, pack with flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_norm_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [MAN_W+3:0] mag_a,
    input  logic [MAN_W+3:0] mag_b,
    input  logic [EXP_W-1:0] exp_pre,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [EXP_W-1:0] res_exp,
    output logic [MAN_W-1:0] res_frac,
    output logic             res_zero,
    output logic             overflow,
    output logic             underflow
);

    localparam int W    = MAN_W + 4;
    localparam int LZ_W = $clog2(W + 1);
    localparam int EW   = EXP_W + 2;

    localparam logic signed [EW-1:0] c_e_one   = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] c_exp_inf = {2'b00, {EXP_W{1'b1}}};
    localparam logic [LZ_W-1:0]      c_lz_one  = {{(LZ_W-1){1'b0}}, 1'b1};

    logic w_en;

    // Stage 1 registers
    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic [W:0]           r_s1_sum;
    logic [EXP_W-1:0]     r_s1_exp;

    // Stage 2 registers
    logic                 r_s2_valid;
    logic                 r_s2_sign;
    logic [W-1:0]         r_s2_m;
    logic signed [EW-1:0] r_s2_e;

    // Stage 1 combinational
    logic [W:0]           w_a_ext;
    logic [W:0]           w_b_ext;
    logic [W:0]           w_sum;
    logic                 w_sign1;

    // Stage 2 combinational
    logic [LZ_W-1:0]      w_lz;
    logic [W-1:0]         w_norm;
    logic signed [EW-1:0] w_e_norm;

    // Stage 3 combinational
    logic                 w_is_zero;
    logic                 w_inc;
    logic [MAN_W:0]       w_frac_rnd;
    logic                 w_carry;
    logic signed [EW-1:0] w_e_rnd;

    // Whole pipe moves together; it only stalls when a finished result is held.
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    function automatic logic [LZ_W-1:0] f_lzc(input logic [W-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + c_lz_one;
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        w_a_ext = {1'b0, mag_a};
        w_b_ext = {1'b0, mag_b};
        w_sum   = '0;
        w_sign1 = sign_a;
        if (sign_a == sign_b) begin
            w_sum = w_a_ext + w_b_ext;
        end else if (mag_a >= mag_b) begin
            w_sum = w_a_ext - w_b_ext;
        end else begin
            w_sum   = w_b_ext - w_a_ext;
            w_sign1 = sign_b;
        end
        // An exact cancellation is +0 under round-to-nearest-even.
        if (w_sum == '0) begin
            w_sign1 = 1'b0;
        end
    end

    always_comb begin
        w_lz = f_lzc(r_s1_sum[W-1:0]);
        if (r_s1_sum[W]) begin
            w_norm   = {r_s1_sum[W:2], r_s1_sum[1] | r_s1_sum[0]};
            w_e_norm = $signed({2'b00, r_s1_exp}) + c_e_one;
        end else begin
            // A zero sum shifts out entirely, leaving the hidden bit clear.
            w_norm   = r_s1_sum[W-1:0] << w_lz;
            w_e_norm = $signed({2'b00, r_s1_exp})
                     - $signed({{(EW-LZ_W){1'b0}}, w_lz});
        end
    end

    always_comb begin
        w_is_zero  = ~r_s2_m[W-1];
        w_inc      = r_s2_m[2] & (r_s2_m[1] | r_s2_m[0] | r_s2_m[3]);
        w_frac_rnd = {1'b0, r_s2_m[W-2:3]} + {{MAN_W{1'b0}}, w_inc};
        // Fraction carry means 1.111..1 rounded up to 10.000..0.
        w_carry    = w_frac_rnd[MAN_W];
        w_e_rnd    = w_carry ? (r_s2_e + c_e_one) : r_s2_e;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_exp   <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= w_sign1;
            r_s1_sum   <= w_sum;
            r_s1_exp   <= exp_pre;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_m     <= '0;
            r_s2_e     <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_m     <= w_norm;
            r_s2_e     <= w_e_norm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_frac  <= '0;
            res_zero  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_s2_valid;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_frac  <= '0;
            res_zero  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (r_s2_valid) begin
                if (w_is_zero) begin
                    res_zero <= 1'b1;
                end else if (w_e_rnd < c_e_one) begin
                    underflow <= 1'b1;
                    res_sign  <= r_s2_sign;
                end else if (w_e_rnd >= c_exp_inf) begin
                    overflow <= 1'b1;
                    res_sign <= r_s2_sign;
                    res_exp  <= '1;
                end else begin
                    res_sign <= r_s2_sign;
                    res_exp  <= w_e_rnd[EXP_W-1:0];
                    res_frac <= w_frac_rnd[MAN_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_norm_pipe
// Description : Scoreboard bench for fp_addsub_norm_pipe with arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_norm_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = MAN_W + 4;

    localparam logic [W-1:0] M_ONE     = 27'h400_0000;
    localparam logic [W-1:0] M_ONE_P5  = 27'h600_0000;
    localparam logic [W-1:0] M_P75     = 27'h300_0000;
    localparam logic [W-1:0] M_TIE_EV  = 27'h400_0004;
    localparam logic [W-1:0] M_TIE_OD  = 27'h400_000C;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
        logic             zero;
        logic             ovf;
        logic             unf;
    } res_t;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic             sign_a    = 1'b0;
    logic             sign_b    = 1'b0;
    logic [W-1:0]     mag_a     = '0;
    logic [W-1:0]     mag_b     = '0;
    logic [EXP_W-1:0] exp_pre   = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             res_sign;
    logic [EXP_W-1:0] res_exp;
    logic [MAN_W-1:0] res_frac;
    logic             res_zero;
    logic             overflow;
    logic             underflow;

    int   checks  = 0;
    int   errors  = 0;
    int   bp_mode = 0;
    res_t sb_q[$];

    fp_addsub_norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .exp_pre   (exp_pre),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sign  (res_sign),
        .res_exp   (res_exp),
        .res_frac  (res_frac),
        .res_zero  (res_zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Value-level model: exact signed sum, scale to 1.xxx, then RNE on the dropped bits.
    function automatic res_t ref_model(input logic sa, input logic sb,
                                       input longint a, input longint b, input int ep);
        res_t   r;
        longint s, m, keep, rem;
        int     p, e;
        r = '0;
        s = (sa ? -a : a) + (sb ? -b : b);
        if (s == 0) begin
            r.zero = 1'b1;
            return r;
        end
        r.sign = (s < 0);
        m = (s < 0) ? -s : s;
        p = 0;
        for (int i = 0; i <= W; i++) if (((m >> i) & 1) != 0) p = i;
        e = ep + p - (W - 1);
        if (p == W) m = (m >> 1) | (m & 1);
        else        m = m << (W - 1 - p);
        keep = m >> 3;
        rem  = m & 7;
        if (rem > 4 || (rem == 4 && (keep & 1) != 0)) keep = keep + 1;
        if (keep == (longint'(1) << (MAN_W + 1))) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e <= 0) begin
            r.unf = 1'b1;
        end else if (e >= (1 << EXP_W) - 1) begin
            r.ovf = 1'b1;
            r.exp = '1;
        end else begin
            r.exp  = e[EXP_W-1:0];
            r.frac = keep[MAN_W-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic sa, input logic sb, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [EXP_W-1:0] ep);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        sign_a   = sa;
        sign_b   = sb;
        mag_a    = a;
        mag_b    = b;
        exp_pre  = ep;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=0 required=1");
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(ref_model(sa, sb, longint'(a), longint'(b), int'(ep)));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_random();
        logic [31:0]      r1, r2;
        logic [W-1:0]     a, b, t;
        logic [EXP_W-1:0] ep;
        int               k;
        r1 = $urandom;
        r2 = $urandom;
        a  = {1'b1, r1[25:0]};
        case ($urandom_range(0, 3))
            0: begin
                k = $urandom_range(0, 26);
                b = {1'b1, r2[25:0]} >> k;
                b[0] = b[0] | r2[31];
            end
            1: b = a ^ {19'd0, r2[7:0]};
            2: b = r2[0] ? a : '0;
            default: b = r2[26:0];
        endcase
        if ($urandom_range(0, 1) == 1) begin
            t = a; a = b; b = t;
        end
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
                0: ep = 8'd1;
                1: ep = 8'd2;
                2: ep = 8'd25;
                3: ep = 8'd253;
                default: ep = 8'd254;
            endcase
        end else begin
            ep = 8'($urandom_range(1, 254));
        end
        send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, ep);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
        end
    endtask

    initial begin : backpressure
        forever begin
            @(negedge clk);
            case (bp_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        res_t                got, want;
        logic [$bits(res_t):0] snap;
        logic                have_snap;
        have_snap = 1'b0;
        snap      = '0;
        forever begin
            @(negedge clk);
            #2;
            got = {res_sign, res_exp, res_frac, res_zero, overflow, underflow};
            if (reset) begin
                have_snap = 1'b0;
            end else begin
                if (have_snap) begin
                    checks++;
                    if ({out_valid, got} !== snap) begin
                        errors++;
                        $display("FAIL hold_stable actual=%0h required=%0h", {out_valid, got}, snap);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output actual=%0h required=none", got);
                    end else begin
                        want = sb_q.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL result actual s=%0b e=%0h f=%0h z=%0b o=%0b u=%0b required s=%0b e=%0h f=%0h z=%0b o=%0b u=%0b",
                                     got.sign, got.exp, got.frac, got.zero, got.ovf, got.unf,
                                     want.sign, want.exp, want.frac, want.zero, want.ovf, want.unf);
                        end
                    end
                end
                have_snap = out_valid && !out_ready;
                snap      = {out_valid, got};
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_flags",     64'({res_zero, overflow, underflow}), 64'd0);
        chk("reset_res",       64'({res_sign, res_exp, res_frac}),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Latency: 1.0 + 1.0 at exp 127 appears exactly three edges after acceptance.
        send(1'b0, 1'b0, M_ONE, M_ONE, 8'd127);
        idle();
        #1 chk("lat_edge1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 chk("lat_edge2", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 chk("lat_edge3", 64'(out_valid), 64'd1);
        chk("lat_exp",  64'(res_exp),  64'd128);
        chk("lat_frac", 64'(res_frac), 64'd0);
        drain();

        send(1'b0, 1'b1, M_ONE,    M_ONE,    8'd127);
        send(1'b0, 1'b1, M_ONE,    M_ONE_P5, 8'd127);
        send(1'b0, 1'b0, M_TIE_EV, '0,       8'd127);
        send(1'b0, 1'b0, M_TIE_OD, '0,       8'd127);
        send(1'b0, 1'b0, M_ONE,    M_ONE,    8'd254);
        send(1'b0, 1'b1, M_ONE,    M_P75,    8'd1);
        send(1'b1, 1'b1, 27'h7FF_FFFF, 27'h000_0004, 8'd100);
        idle();
        drain();

        // Backpressure: four back-to-back operands with the sink stalled.
        bp_mode = 1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_random();
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
                repeat (2) @(negedge clk);
                bp_mode = 0;
            end
        join
        drain();

        // Reset mid-stream discards everything in flight.
        bp_mode = 1;
        for (int i = 0; i < 3; i++) send_random();
        idle();
        @(negedge clk);
        #1 chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 chk("reset_mid_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        bp_mode = 0;
        repeat (6) @(negedge clk);
        send(1'b0, 1'b0, M_ONE, M_P75, 8'd60);
        idle();
        drain();

        // Randomised traffic with random sink backpressure.
        bp_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else                           send_random();
        end
        idle();
        bp_mode = 0;
        drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
